// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the parametrised synchronous FIFO.
// Revision 1.0
`default_nettype none

package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Occupancy must represent 0..DEPTH, one bit wider than the pointers.
  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_dpram.sv
// fifo_dpram: DATA_W x DEPTH storage, synchronous write, asynchronous read.
// Revision 1.0
`default_nettype none

module fifo_dpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with thresholds, sticky errors, STD/FWFT output.
// Revision 1.0
`default_nettype none

module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int AF_LEVEL = 60,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = FIFO_MODE_STD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] buf_in,
  input  logic              rd,
  input  logic              err_clr,
  output logic [DATA_W-1:0] buf_out,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   fifo_cntr,
  output logic              overflow,
  output logic              underflow
);

  localparam int             DEPTH   = 1 << ADDR_W;
  localparam int             CW      = cnt_width(ADDR_W);
  localparam logic [CW-1:0]  C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0]  C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0]  C_AE    = CW'(AE_LEVEL);
  localparam logic [CW-1:0]  C_ONE   = CW'(1);

  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_param_check
    $error("fifo_sync_param: require AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              r_empty;
  logic              r_full;
  logic              r_ae;
  logic              r_af;
  logic              r_ovf;
  logic              r_udf;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [DATA_W-1:0] w_rd_data;

  // A read into a full FIFO frees a slot, so a simultaneous write still lands.
  assign w_rd_acc = rd & ~r_empty;
  assign w_wr_acc = wr & (~r_full | w_rd_acc);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_wr_acc && !w_rd_acc) begin
      w_cnt_nxt = r_cnt + C_ONE;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_cnt_nxt = r_cnt - C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_ae     <= 1'b1;
      r_af     <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt   <= w_cnt_nxt;
      // Flags follow the next count so they never lag fifo_cntr.
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == C_DEPTH);
      r_ae    <= (w_cnt_nxt <= C_AE);
      r_af    <= (w_cnt_nxt >= C_AF);
      r_ovf   <= (wr & ~w_wr_acc) | (r_ovf & ~err_clr);
      r_udf   <= (rd & ~w_rd_acc) | (r_udf & ~err_clr);
    end
  end

  fifo_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (buf_in),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign buf_out  = w_rd_data;
    assign rd_valid = ~r_empty;
  end else begin : g_std
    logic [DATA_W-1:0] r_buf_out;
    logic              r_rd_valid;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_buf_out  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_buf_out <= w_rd_data;
      end
    end

    assign buf_out  = r_buf_out;
    assign rd_valid = r_rd_valid;
  end

  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_ae;
  assign almost_full  = r_af;
  assign fifo_cntr    = r_cnt;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed checks of a 4-deep standard FIFO and a 4-deep FWFT FIFO.
// Revision 1.0
`default_nettype none

module tb_fifo_sync_param;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance
  logic       rst_n, wr, rd, err_clr;
  logic [7:0] buf_in, buf_out;
  logic       rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [2:0] fifo_cntr;

  // FWFT instance
  logic       f_rst_n, f_wr, f_rd, f_err_clr;
  logic [7:0] f_buf_in, f_buf_out;
  logic       f_rd_valid, f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
  logic [2:0] f_cntr;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_sync_param #(.DATA_W(8), .ADDR_W(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr(wr), .buf_in(buf_in), .rd(rd), .err_clr(err_clr),
    .buf_out(buf_out), .rd_valid(rd_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .fifo_cntr(fifo_cntr),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_param #(.DATA_W(8), .ADDR_W(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(f_rst_n), .wr(f_wr), .buf_in(f_buf_in), .rd(f_rd), .err_clr(f_err_clr),
    .buf_out(f_buf_out), .rd_valid(f_rd_valid), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .fifo_cntr(f_cntr),
    .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr = w; buf_in = d; rd = r; err_clr = c;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; buf_in = 8'h00;
    f_rst_n = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_err_clr = 1'b0; f_buf_in = 8'h00;
    tick();
    tick();

    // Reset state
    chk("rst_cnt", fifo_cntr, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_bufout", buf_out, 0);
    chk("f_rst_empty", f_empty, 1);
    chk("f_rst_valid", f_rd_valid, 0);
    rst_n = 1'b1;
    f_rst_n = 1'b1;

    // Fill: 11,22,33,44
    drive(1, 8'h11, 0, 0);
    chk("fill1_cnt", fifo_cntr, 1);
    chk("fill1_empty", empty, 0);
    chk("fill1_ae", almost_empty, 1);
    drive(1, 8'h22, 0, 0);
    chk("fill2_ae", almost_empty, 0);
    chk("fill2_af", almost_full, 0);
    drive(1, 8'h33, 0, 0);
    chk("fill3_af", almost_full, 1);
    chk("fill3_full", full, 0);
    drive(1, 8'h44, 0, 0);
    chk("fill4_cnt", fifo_cntr, 4);
    chk("fill4_full", full, 1);
    chk("fill4_af", almost_full, 1);
    chk("fill4_empty", empty, 0);
    chk("fill4_valid", rd_valid, 0);

    // Overflow on write while full
    drive(1, 8'h55, 0, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_cnt", fifo_cntr, 4);
    drive(0, 8'h00, 0, 1);
    chk("ovf_clr", overflow, 0);

    // Simultaneous rd & wr while full
    drive(1, 8'h66, 1, 0);
    chk("rw_full_cnt", fifo_cntr, 4);
    chk("rw_full_out", buf_out, 8'h11);
    chk("rw_full_valid", rd_valid, 1);
    chk("rw_full_ovf", overflow, 0);
    chk("rw_full_full", full, 1);

    // Drain: 22,33,44,66
    drive(0, 8'h00, 1, 0);
    chk("drain1_out", buf_out, 8'h22);
    chk("drain1_valid", rd_valid, 1);
    chk("drain1_full", full, 0);
    drive(0, 8'h00, 1, 0);
    chk("drain2_out", buf_out, 8'h33);
    drive(0, 8'h00, 1, 0);
    chk("drain3_out", buf_out, 8'h44);
    chk("drain3_ae", almost_empty, 1);
    drive(0, 8'h00, 1, 0);
    chk("drain4_out", buf_out, 8'h66);
    chk("drain4_valid", rd_valid, 1);
    chk("drain4_empty", empty, 1);
    chk("drain4_cnt", fifo_cntr, 0);
    drive(0, 8'h00, 0, 0);
    chk("idle_valid", rd_valid, 0);
    chk("idle_hold", buf_out, 8'h66);

    // Underflow and sticky behaviour
    drive(0, 8'h00, 1, 0);
    chk("udf_set", underflow, 1);
    chk("udf_hold_out", buf_out, 8'h66);
    chk("udf_valid", rd_valid, 0);
    chk("udf_cnt", fifo_cntr, 0);
    drive(0, 8'h00, 1, 1);
    chk("udf_setwins", underflow, 1);
    drive(0, 8'h00, 0, 1);
    chk("udf_clr", underflow, 0);

    // Empty with rd & wr: write lands, read rejected
    drive(1, 8'h77, 1, 0);
    chk("erw_cnt", fifo_cntr, 1);
    chk("erw_udf", underflow, 1);
    chk("erw_valid", rd_valid, 0);
    drive(0, 8'h00, 1, 1);
    chk("erw_out", buf_out, 8'h77);
    chk("erw_udf_clr", underflow, 0);
    chk("erw_empty", empty, 1);

    // Wrap-around: alternating write/read of A0+i
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'hA0 + 8'(i), 0, 0);
      chk($sformatf("wrap%0d_wcnt", i), fifo_cntr, 1);
      drive(0, 8'h00, 1, 0);
      chk($sformatf("wrap%0d_out", i), buf_out, 8'hA0 + i);
      chk($sformatf("wrap%0d_valid", i), rd_valid, 1);
      chk($sformatf("wrap%0d_rcnt", i), fifo_cntr, 0);
    end
    chk("wrap_ovf", overflow, 0);
    chk("wrap_udf", underflow, 0);

    // Reset with contents and a flag set
    drive(0, 8'h00, 1, 0);
    drive(1, 8'hB1, 0, 0);
    drive(1, 8'hB2, 0, 0);
    chk("prerst_cnt", fifo_cntr, 2);
    chk("prerst_udf", underflow, 1);
    rst_n = 1'b0;
    drive(1, 8'hB3, 1, 0);
    chk("midrst_cnt", fifo_cntr, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_udf", underflow, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_valid", rd_valid, 0);
    chk("midrst_out", buf_out, 0);
    chk("midrst_ae", almost_empty, 1);
    rst_n = 1'b1;
    drive(0, 8'h00, 0, 0);

    // FWFT mode
    f_wr = 1'b1; f_buf_in = 8'h5A;
    tick();
    f_wr = 1'b0;
    chk("f_wr_valid", f_rd_valid, 1);
    chk("f_wr_out", f_buf_out, 8'h5A);
    chk("f_wr_empty", f_empty, 0);
    tick();
    chk("f_hold_out", f_buf_out, 8'h5A);
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
    chk("f_pop_empty", f_empty, 1);
    chk("f_pop_valid", f_rd_valid, 0);
    chk("f_pop_cnt", f_cntr, 0);
    f_wr = 1'b1; f_rd = 1'b1; f_buf_in = 8'h01;
    tick();
    f_rd = 1'b0; f_buf_in = 8'h02;
    chk("f_erw_cnt", f_cntr, 1);
    chk("f_erw_udf", f_udf, 1);
    chk("f_erw_valid", f_rd_valid, 1);
    chk("f_erw_out", f_buf_out, 8'h01);
    tick();
    f_wr = 1'b0;
    chk("f_two_cnt", f_cntr, 2);
    chk("f_two_out", f_buf_out, 8'h01);
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
    chk("f_next_out", f_buf_out, 8'h02);
    chk("f_next_valid", f_rd_valid, 1);
    chk("f_next_cnt", f_cntr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO. It is the next generation of the team's 64x8 buffer, with configurable data width and depth.
- Adds almost-full and almost-empty thresholds.
- Adds sticky overflow/underflow error flags.
- Offers a selectable output mode: registered (standard) or first-word-fall-through (FWFT).
- Used as the generic buffering element between producer and consumer stages in one clock domain.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 6: pointer width; DEPTH = 2**ADDR_W entries.
- AF_LEVEL, 60: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 4: almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- wr  in  1  write request.
- buf_in  in  DATA_W  write data.
- rd  in  1  read request (pop in FWFT mode).
- err_clr  in  1  clears overflow/underflow flags.
- buf_out  out  DATA_W  read data.
- rd_valid  out  1  buf_out holds valid data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_LEVEL.
- almost_full  out  1  count >= AF_LEVEL.
- fifo_cntr  out  ADDR_W+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while not accepted.
- underflow  out  1  sticky: read attempted while not accepted.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Pointers = 0, fifo_cntr = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0, rd_valid = 0, buf_out = 0.
  - Memory contents are not reset.
  - Reset wins over every other input in the same cycle. Reset mid-transfer discards all contents.
- Accept rules, evaluated on registered state:
  - rd_acc = rd & ~empty.
  - wr_acc = wr & (~full | rd_acc). When full, a simultaneous read frees a slot, so the write is accepted.
- Pointers: increment on their accept and wrap modulo DEPTH (natural ADDR_W overflow).
- Count:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
  - Never exceeds DEPTH and never goes below 0.
- Flags are registered and derived from the next count in the same cycle, so they are always consistent with fifo_cntr. No flag lags by a cycle.
- Empty with rd & wr in the same cycle: write accepted, read rejected, underflow set. Exception: FWFT never bypasses data in the same cycle.
- Error flags:
  - overflow <= 1 on wr & ~wr_acc.
  - underflow <= 1 on rd & ~rd_acc.
  - Both hold until err_clr = 1 or reset. If err_clr coincides with a new error, the flag stays set (set wins).
- Standard mode (FWFT = 0):
  - On rd_acc, buf_out <= mem[rd_ptr] at the same edge, so data is visible 1 cycle after the rd request.
  - rd_valid pulses high for exactly that cycle.
  - buf_out holds its last value otherwise. Never drive Z.
- FWFT mode (FWFT = 1):
  - buf_out = mem[rd_ptr] whenever ~empty; rd_valid = ~empty.
  - rd pops the head; the new head appears combinationally after the edge.
  - A word written into an empty FIFO appears on buf_out 1 cycle after the write edge.
  - When empty, buf_out is don't-care; the bench checks it only when rd_valid = 1.
- Write-to-read ordering: strict FIFO. Data written at edge N is readable from edge N+1.
- Elaboration check: AE_LEVEL < AF_LEVEL <= DEPTH.

Decomposition:
- Shared package fifo_pkg:
  - Mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
  - A function computing count width from ADDR_W.
- One natural sub-module, fifo_dpram:
  - DATA_W x DEPTH storage.
  - Synchronous write port.
  - Asynchronous read port (the top adds the output register in standard mode).
- Control (pointers, count, flags) stays in fifo_sync_param.

Test Plan:
- DATA_W=8, ADDR_W=2, AF=3, AE=1, FWFT=0. Reset, then write 0x11,0x22,0x33,0x44.
  - After the 4th edge: fifo_cntr = 4, full = 1, almost_full = 1, empty = 0.
  - A 5th write of 0x55 sets overflow = 1 and leaves the count at 4.
- Same configuration, full. Read 4 times.
  - buf_out = 0x11,0x22,0x33,0x44, each 1 cycle after rd, with a single-cycle rd_valid pulse.
  - Then empty = 1. A further rd sets underflow; buf_out stays 0x44.
- Full, with rd & wr of 0x66 together.
  - Both accepted, count stays 4, buf_out = 0x11, overflow stays 0.
  - Later drain order ends ...,0x44,0x66.
- Wrap-around: 10 cycles of alternating single write/read of 0xA0+i.
  - Outputs match in order, pointers wrap past 3, count is never > 1.
- FWFT=1: write 0x5A into an empty FIFO.
  - Next cycle: rd_valid = 1, buf_out = 0x5A with no rd.
  - rd pops it, giving empty = 1 and rd_valid = 0.
- Sticky flags and reset:
  - Set underflow, then assert err_clr together with another empty rd: underflow stays 1.
  - err_clr alone clears it.
  - rst_n low with 2 entries stored: next edge gives count = 0, empty = 1, all flags 0.
